// File: rtl/detector_seq_ctrl_if.sv
// detector_seq_ctrl_if: CPU slave bus, source MM master port, ST monitor taps and irq
interface detector_seq_ctrl_if;
  logic [1:0]  s_address;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_read;
  logic [31:0] s_readdata;
  logic        m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        st_valid;
  logic        st_endofpacket;
  logic        irq;
  modport slave (
    input  s_address, s_write, s_writedata, s_read, st_valid, st_endofpacket,
    output s_readdata, m_address, m_write, m_writedata, irq
  );
  modport master (
    output s_address, s_write, s_writedata, s_read, st_valid, st_endofpacket,
    input  s_readdata, m_address, m_write, m_writedata, irq
  );
endinterface

// File: rtl/detector_seq_ctrl.sv
// detector_seq_ctrl: runs background then image frame phases on the test-pattern source
module detector_seq_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  detector_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR_BG, WR_GO, RUN_BG, WR_IMG, RUN_IMG, WR_STOP} state_t;
  state_t state, state_nxt;
  logic loop, irq_en, done, aborted, via_abort;
  logic [CNT_WIDTH-1:0] bg_frames, img_frames, act_bg, act_img, frame_cnt, cnt_inc;
  logic [31:0] background;
  logic ctrl_wr, cnt_wr, bgv_wr, sts_wr, start, abort, ev, hit, wr_nxt;
  assign ctrl_wr = bus.s_write && bus.s_address == 2'd0;
  assign cnt_wr  = bus.s_write && bus.s_address == 2'd1;
  assign bgv_wr  = bus.s_write && bus.s_address == 2'd2;
  assign sts_wr  = bus.s_write && bus.s_address == 2'd3;
  assign start   = ctrl_wr && bus.s_writedata[0] && !bus.s_writedata[1] && state == IDLE;
  assign abort   = ctrl_wr && bus.s_writedata[1] && state != IDLE && state != WR_STOP;
  assign ev      = bus.st_valid && bus.st_endofpacket && (state == RUN_BG || state == RUN_IMG);
  assign cnt_inc = frame_cnt + 1'b1;
  assign hit     = ev && cnt_inc == (state == RUN_BG ? act_bg : act_img);
  assign bus.irq = done & irq_en;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? WR_BG : IDLE;
      WR_BG:   state_nxt = WR_GO;
      WR_GO:   state_nxt = act_bg != '0 ? RUN_BG : act_img != '0 ? RUN_IMG : WR_STOP;
      RUN_BG:  state_nxt = !hit ? RUN_BG : act_img != '0 ? WR_IMG : loop ? WR_BG : WR_STOP;
      WR_IMG:  state_nxt = RUN_IMG;
      RUN_IMG: state_nxt = !hit ? RUN_IMG : loop ? WR_BG : WR_STOP;
      WR_STOP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = WR_STOP;
    wr_nxt = state_nxt inside {WR_BG, WR_GO, WR_IMG, WR_STOP};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {loop, irq_en, done, aborted, via_abort} <= '0;
      {bg_frames, img_frames, act_bg, act_img, frame_cnt} <= '0;
      background <= '0;
      bus.m_write <= 1'b0;
      bus.m_address <= 1'b0;
      bus.m_writedata <= '0;
      bus.s_readdata <= '0;
    end else begin
      state <= state_nxt;
      bus.m_write <= wr_nxt;
      if (wr_nxt) begin
        bus.m_address <= state_nxt == WR_BG;
        bus.m_writedata <= state_nxt == WR_BG ? background :
                           state_nxt == WR_GO ? (act_bg != '0 ? 32'h3 : 32'h1) :
                           state_nxt == WR_IMG ? 32'h1 : 32'h0;
      end
      // Programmed counts only become active at the start of a run or loop pass
      if (state_nxt == WR_BG) begin
        act_bg <= bg_frames;
        act_img <= img_frames;
      end
      if (ctrl_wr) begin
        loop <= bus.s_writedata[2];
        irq_en <= bus.s_writedata[3];
      end
      if (cnt_wr) begin
        bg_frames <= bus.s_writedata[CNT_WIDTH-1:0];
        img_frames <= bus.s_writedata[16+:CNT_WIDTH];
      end
      if (bgv_wr) background <= bus.s_writedata;
      if (sts_wr && bus.s_writedata[1]) done <= 1'b0;
      if (sts_wr && bus.s_writedata[2]) aborted <= 1'b0;
      if (ev) frame_cnt <= hit ? '0 : cnt_inc;
      if (start) begin
        done <= 1'b0;
        frame_cnt <= '0;
      end
      if (abort) via_abort <= 1'b1;
      if (state == WR_STOP) begin
        via_abort <= 1'b0;
        if (via_abort) aborted <= 1'b1;
        else done <= 1'b1;
      end
      bus.s_readdata <= !bus.s_read ? 32'd0 :
                        bus.s_address == 2'd0 ? {28'd0, irq_en, loop, 2'b00} :
                        bus.s_address == 2'd1 ? (32'(img_frames) << 16) | 32'(bg_frames) :
                        bus.s_address == 2'd2 ? background :
                        {16'(frame_cnt), 9'd0, state, 1'b0, aborted, done, state != IDLE};
    end
  end
endmodule
